lfsr_stream: RTL and testbench
==============================

# lfsr_stream

Parametrised Fibonacci LFSR pseudo-random source with seed load, zero-lock-up recovery, period-wrap flag and a valid/ready output handshake. Successor to the fixed 8-bit free-running LFSR. It feeds randomised stimulus and data words to downstream consumers that may apply backpressure. Width and feedback polynomial are set at elaboration time.

## Interface
Parameters:
- WIDTH, 8: state/output width; legal range 3..32.
- TAPS, 8'hB8: WIDTH-bit feedback mask. TAPS[WIDTH-1] must be 1 and TAPS must be nonzero. Default gives the maximal 8-bit polynomial x^8+x^6+x^5+x^4+1.
- RESET_SEED, 1: WIDTH-bit state after reset and substitute for a zero seed; must be nonzero.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  advance enable; when 0 the state holds even if a transfer is offered.
- load  in  1  load `seed` into state this cycle.
- seed  in  WIDTH  seed value, sampled when load=1.
- ready  in  1  consumer accepts `random` this cycle.
- valid  out  1  `random` holds a valid word.
- random  out  WIDTH  current LFSR state, registered.
- wrap  out  1  one-cycle pulse: state returned to the start value.
- lockup_err  out  1  one-cycle pulse: zero seed rejected.

## Operation
- Feedback: fb = XOR-reduce(state & TAPS). Next state = {state[WIDTH-2:0], fb}, a left shift.
- The `start` register holds the value of the most recent reset or load. It is internal.
- A transfer occurs when valid && ready.
- State advances when transfer && en && !load.
- Priority, highest first: reset, load, advance, hold.
- Reset:
  - random = RESET_SEED and start = RESET_SEED.
  - valid = 0, wrap = 0, lockup_err = 0.
- Load with seed != 0:
  - state = seed, start = seed, wrap = 0.
- Load with seed == 0:
  - state = RESET_SEED, start = RESET_SEED.
  - lockup_err = 1 for one cycle.
- Load in the same cycle as a transfer:
  - The transfer completes; the consumer took the old value.
  - The next state is the seed, not the advanced value.
- Advance:
  - state = next.
  - wrap = 1 for one cycle when next == start; otherwise 0.
- ready=0 or en=0: state, valid and random hold. wrap and lockup_err return to 0.
- The all-zero state is unreachable: reset, load and feedback never produce it.

## Timing
- All outputs are registered. Each output changes exactly one cycle after the qualifying edge.
- valid:
  - 0 during reset.
  - Goes to 1 on the first edge with reset=0.
  - Then stays 1; load does not drop it.
- Advance latency: a transfer at edge N shows the new `random` after edge N. Full throughput is one word per cycle with ready=1.
- Load latency: the seed appears on `random` after the load edge. lockup_err is coincident with that value.
- Wrap: asserted in the same cycle `random` equals `start` after an advance. Does not assert on reset or load.
- Period: with a maximal TAPS, wrap fires every 2^WIDTH-1 advances.
- Reset mid-stream: state restarts at RESET_SEED on the next edge. Pending wrap and lockup_err pulses clear.

## Test plan
1. Reset, WIDTH=8 defaults:
   - Hold reset 2 cycles -> random=0x01, valid=0, wrap=0, lockup_err=0.
   - Release reset -> valid=1 after one edge.
2. Free run, en=1, ready=1:
   - random goes 01,02,04,08,11,23,47,8E on successive cycles.
   - Drop ready for 3 cycles at 0x11 -> holds 0x11.
   - Repeat with en=0 instead of ready=0 -> holds 0x11.
3. Full period:
   - Load seed 0x01, then 255 advances.
   - wrap pulses exactly once, on the 255th, with random=0x01.
   - All 255 values are distinct and nonzero.
4. Load corner cases:
   - load with seed=0x00 -> random=0x01 and lockup_err=1 for one cycle.
   - load with seed=0x5A while ready=1, en=1 -> random=0x5A, not advanced.
   - Reset mid-run at 0x47 -> 0x01.
5. Second configuration, WIDTH=4, TAPS=4'h9, RESET_SEED=1:
   - Sequence 1,3,7,F,E,D,A,5,B,6,C,9,2,4,8.
   - Then 1 with wrap=1; period 15.

Source files
------------

// File: rtl/lfsr_stream.sv
// lfsr_stream: parametrised Fibonacci LFSR word source with seed load,
// zero-seed recovery, period-wrap pulse and a valid/ready output handshake.
// The LFSR state register drives `random` directly, so every output is a flop.
module lfsr_stream #(
  parameter int unsigned            WIDTH      = 8,
  parameter logic [WIDTH-1:0]       TAPS       = 8'hB8,
  parameter logic [WIDTH-1:0]       RESET_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] random,
  output logic             wrap,
  output logic             lockup_err
);

  // One Fibonacci step: shift left, feedback is the parity of the tapped bits.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    lfsr_step = {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  logic [WIDTH-1:0] state_r;
  logic [WIDTH-1:0] start_r;
  logic             valid_r;
  logic             wrap_r;
  logic             lockup_r;

  logic [WIDTH-1:0] step_s;
  logic             advance_s;
  logic [WIDTH-1:0] state_nxt_s;
  logic [WIDTH-1:0] start_nxt_s;
  logic             wrap_nxt_s;
  logic             lockup_nxt_s;

  assign step_s    = lfsr_step(state_r);
  // A consumer transfer moves the stream only if enabled and no load overrides it.
  assign advance_s = valid_r && ready && en && !load;

  // Next-state selection: load beats advance beats hold; pulses default low.
  always_comb begin
    state_nxt_s  = state_r;
    start_nxt_s  = start_r;
    wrap_nxt_s   = 1'b0;
    lockup_nxt_s = 1'b0;
    if (load) begin
      if (seed == {WIDTH{1'b0}}) begin
        // A zero seed would lock the LFSR; substitute the reset seed and flag it.
        state_nxt_s  = RESET_SEED;
        start_nxt_s  = RESET_SEED;
        lockup_nxt_s = 1'b1;
      end else begin
        state_nxt_s  = seed;
        start_nxt_s  = seed;
      end
    end else if (advance_s) begin
      state_nxt_s = step_s;
      wrap_nxt_s  = (step_s == start_r);
    end else begin
      state_nxt_s = state_r;
      start_nxt_s = start_r;
    end
  end

  // State, start value, handshake and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= RESET_SEED;
      start_r  <= RESET_SEED;
      valid_r  <= 1'b0;
      wrap_r   <= 1'b0;
      lockup_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      start_r  <= start_nxt_s;
      valid_r  <= 1'b1;
      wrap_r   <= wrap_nxt_s;
      lockup_r <= lockup_nxt_s;
    end
  end

  assign valid      = valid_r;
  assign random     = state_r;
  assign wrap       = wrap_r;
  assign lockup_err = lockup_r;

endmodule

// File: tb/tb_lfsr_stream.sv
// tb_lfsr_stream: directed bench for lfsr_stream in the default 8-bit
// configuration and a 4-bit (x^4+x+1 style, TAPS=4'h9) configuration.
module tb_lfsr_stream;

  logic       clk = 1'b0;
  int         checks = 0;
  int         failures = 0;

  // 8-bit instance signals
  logic       reset8, en8, load8, ready8;
  logic [7:0] seed8;
  logic       valid8, wrap8, lock8;
  logic [7:0] random8;

  // 4-bit instance signals
  logic       reset4, en4, load4, ready4;
  logic [3:0] seed4;
  logic       valid4, wrap4, lock4;
  logic [3:0] random4;

  lfsr_stream u8 (
    .clk(clk), .reset(reset8), .en(en8), .load(load8), .seed(seed8),
    .ready(ready8), .valid(valid8), .random(random8), .wrap(wrap8),
    .lockup_err(lock8)
  );

  lfsr_stream #(.WIDTH(4), .TAPS(4'h9), .RESET_SEED(4'h1)) u4 (
    .clk(clk), .reset(reset4), .en(en4), .load(load4), .seed(seed4),
    .ready(ready4), .valid(valid4), .random(random4), .wrap(wrap4),
    .lockup_err(lock4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] seq8 [0:3] = '{8'h02, 8'h04, 8'h08, 8'h11};
  logic [3:0] seq4 [0:14] = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB,
                              4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};
  bit         seen [0:255];
  int         distinct_cnt;
  int         wrap_cnt;
  int         zero_cnt;
  int         wrap_step;

  initial begin
    reset8 = 1'b1; en8 = 1'b0; load8 = 1'b0; ready8 = 1'b0; seed8 = 8'h00;
    reset4 = 1'b1; en4 = 1'b0; load4 = 1'b0; ready4 = 1'b0; seed4 = 4'h0;

    // 1. reset state
    tick(); tick();
    check("rst_random", 32'(random8), 32'h01);
    check("rst_valid",  32'(valid8),  32'h0);
    check("rst_wrap",   32'(wrap8),   32'h0);
    check("rst_lock",   32'(lock8),   32'h0);

    reset8 = 1'b0; en8 = 1'b1; ready8 = 1'b1;
    tick();
    check("valid_up",     32'(valid8),  32'h1);
    check("first_random", 32'(random8), 32'h01);

    // 2. free run up to 0x11
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("run_%0d", i), 32'(random8), 32'(seq8[i]));
    end

    ready8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_ready", 32'(random8), 32'h11);
      check("hold_ready_valid", 32'(valid8), 32'h1);
    end
    ready8 = 1'b1; en8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_en", 32'(random8), 32'h11);
    end
    en8 = 1'b1;
    tick(); check("run_23", 32'(random8), 32'h23);
    tick(); check("run_47", 32'(random8), 32'h47);

    // 4c. reset mid-run at 0x47
    reset8 = 1'b1;
    tick();
    check("midrst_random", 32'(random8), 32'h01);
    check("midrst_valid",  32'(valid8),  32'h0);
    reset8 = 1'b0;
    tick();
    check("midrst_release", 32'(random8), 32'h01);
    check("midrst_valid_up", 32'(valid8), 32'h1);

    // 3. full period from seed 0x01
    load8 = 1'b1; seed8 = 8'h01;
    tick();
    check("load01", 32'(random8), 32'h01);
    check("load01_wrap", 32'(wrap8), 32'h0);
    load8 = 1'b0;
    distinct_cnt = 0; wrap_cnt = 0; zero_cnt = 0; wrap_step = -1;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    seen[random8] = 1'b1;
    distinct_cnt = 1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (wrap8) begin
        wrap_cnt++;
        wrap_step = i;
      end
      if (random8 == 8'h00) zero_cnt++;
      if (i < 255) begin
        if (!seen[random8]) distinct_cnt++;
        seen[random8] = 1'b1;
      end
    end
    check("period_random", 32'(random8), 32'h01);
    check("period_wrap_last", 32'(wrap8), 32'h1);
    check("period_wrap_cnt", 32'(wrap_cnt), 32'd1);
    check("period_wrap_step", 32'(wrap_step), 32'd255);
    check("period_distinct", 32'(distinct_cnt), 32'd255);
    check("period_nonzero", 32'(zero_cnt), 32'd0);

    // 4a. zero seed rejected
    load8 = 1'b1; seed8 = 8'h00;
    tick();
    check("zload_random", 32'(random8), 32'h01);
    check("zload_lock",   32'(lock8),   32'h1);
    check("zload_wrap",   32'(wrap8),   32'h0);
    load8 = 1'b0;
    tick();
    check("zload_lock_clr", 32'(lock8), 32'h0);
    check("zload_adv", 32'(random8), 32'h02);

    // 4b. load during a transfer wins over advance
    load8 = 1'b1; seed8 = 8'h5A;
    tick();
    check("load5a", 32'(random8), 32'h5A);
    check("load5a_lock", 32'(lock8), 32'h0);
    load8 = 1'b0;
    tick();
    check("load5a_adv", 32'(random8), 32'hB4);

    // 5. 4-bit configuration
    tick();
    check("w4_rst", 32'(random4), 32'h1);
    reset4 = 1'b0; en4 = 1'b1; ready4 = 1'b1;
    tick();
    check("w4_valid", 32'(valid4), 32'h1);
    check("w4_first", 32'(random4), 32'h1);
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("w4_seq_%0d", i), 32'(random4), 32'(seq4[i]));
      check($sformatf("w4_wrap_%0d", i), 32'(wrap4), (i == 14) ? 32'h1 : 32'h0);
    end
    tick();
    check("w4_after_wrap", 32'(random4), 32'h3);
    check("w4_wrap_clr", 32'(wrap4), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
